// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and width helpers for the SRAM bank arbiter.
//               arb_state_e  - lock state of the request channel
//               bank_w()     - bank-select width derived from the bank count
//               tag_w()      - requestor-tag width, $clog2(NUM_REQ)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int tag_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arbiter_if
// Description : Bundles the requestor-side and bank-side buses of the arbiter.
//               master : arbiter view (consumes m_* requests, drives s_req_*,
//                        consumes s_resp_*, drives m_resp_* and the error flag)
//               slave  : environment view (requestors + bank stage)
//               Packed per-port fields place port i at [i*W +: W].
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bank_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int BANK_W     = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            m_valid;
    logic [NUM_REQ-1:0]            m_we;
    logic [NUM_REQ*BANK_W-1:0]     m_bank;
    logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_REQ-1:0]            m_ready;
    logic [NUM_REQ-1:0]            m_resp_valid;
    logic [DATA_WIDTH-1:0]         m_resp_rdata;

    logic                          s_req_valid;
    logic                          s_req_we;
    logic [BANK_W-1:0]             s_req_bank;
    logic [ADDR_WIDTH-1:0]         s_req_addr;
    logic [DATA_WIDTH-1:0]         s_req_wdata;
    logic                          s_req_ready;
    logic                          s_resp_valid;
    logic [DATA_WIDTH-1:0]         s_resp_rdata;

    logic                          err_unexpected_resp;

    modport master (
        input  m_valid, m_we, m_bank, m_addr, m_wdata,
        output m_ready, m_resp_valid, m_resp_rdata,
        output s_req_valid, s_req_we, s_req_bank, s_req_addr, s_req_wdata,
        input  s_req_ready, s_resp_valid, s_resp_rdata,
        output err_unexpected_resp
    );

    modport slave (
        output m_valid, m_we, m_bank, m_addr, m_wdata,
        input  m_ready, m_resp_valid, m_resp_rdata,
        input  s_req_valid, s_req_we, s_req_bank, s_req_addr, s_req_wdata,
        output s_req_ready, s_resp_valid, s_resp_rdata,
        input  err_unexpected_resp
    );
endinterface
`default_nettype wire

// File: rtl/sram_bank_arbiter_resp_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_tag_fifo
// Description : In-order FIFO of requestor tags for outstanding bank requests.
//               Count-based full/empty; head is visible combinationally.
// Ports       : clk, rst_n (async, active-low), push_i/wdata_i, pop_i,
//               head_o, full_o, empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module resp_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage carries no reset: only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arbiter
// Description : Round-robin merge of NUM_REQ requestors onto one bank request
//               channel. Grant is locked while the bank back-pressures; the
//               source of each accepted request is queued so in-order bank
//               responses are routed back. A same-cycle response with an empty
//               tag FIFO bypasses to the current grantee.
// Ports       : clk, rst_n (async, active-low), bus (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4
) (
    input wire logic            clk,
    input wire logic            rst_n,
    sram_bank_arbiter_if.master bus
);
    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int TAG_W  = tag_w(NUM_REQ);

    arb_state_e       lock_q;
    logic [TAG_W-1:0] gnt_q;
    logic [TAG_W-1:0] ptr_q;
    logic [TAG_W-1:0] ptr_d;
    logic             err_q;
    logic             err_d;

    logic [TAG_W-1:0] pick_idx;
    logic             pick_found;
    logic [TAG_W-1:0] sel;
    logic             sel_valid;
    logic             xfer;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_head;
    logic [TAG_W-1:0] route_tag;
    logic             resp_to_head;
    logic             resp_bypass;
    logic             push;
    logic             pop;

    // First valid requestor at or after ptr, modulo NUM_REQ. The extra index
    // bit holds ptr+k before the wrap subtraction.
    always_comb begin : p_pick
        logic [TAG_W:0] idx;
        idx        = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (idx >= (TAG_W+1)'(NUM_REQ)) begin
                idx = idx - (TAG_W+1)'(NUM_REQ);
            end
            if (!pick_found && bus.m_valid[idx[TAG_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx[TAG_W-1:0];
            end
        end
    end

    assign sel       = (lock_q == ARB_HOLD) ? gnt_q : pick_idx;
    assign sel_valid = (lock_q == ARB_HOLD) ? bus.m_valid[gnt_q] : pick_found;

    // A full tag FIFO blocks issue outright, even if a response pops this cycle.
    assign bus.s_req_valid = sel_valid & ~fifo_full;
    assign xfer            = bus.s_req_valid & bus.s_req_ready;

    // Response routing: FIFO head first; with an empty FIFO a response can
    // only belong to the request being accepted in this same cycle.
    assign resp_to_head = bus.s_resp_valid & ~fifo_empty;
    assign resp_bypass  = bus.s_resp_valid & fifo_empty & xfer;
    assign route_tag    = resp_to_head ? fifo_head : sel;
    assign push         = xfer & ~resp_bypass;
    assign pop          = resp_to_head;
    assign err_d        = err_q | (bus.s_resp_valid & fifo_empty & ~xfer);

    assign ptr_d = (sel == TAG_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

    assign bus.m_resp_rdata        = bus.s_resp_rdata;
    assign bus.err_unexpected_resp = err_q;

    always_comb begin
        bus.s_req_we     = 1'b0;
        bus.s_req_bank   = '0;
        bus.s_req_addr   = '0;
        bus.s_req_wdata  = '0;
        bus.m_ready      = '0;
        bus.m_resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == TAG_W'(i)) begin
                bus.s_req_we    = bus.m_we[i];
                bus.s_req_bank  = bus.m_bank[i*BANK_W +: BANK_W];
                bus.s_req_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus.s_req_wdata = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                bus.m_ready[i]  = xfer;
            end
            if (route_tag == TAG_W'(i)) begin
                bus.m_resp_valid[i] = resp_to_head | resp_bypass;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= ARB_IDLE;
            gnt_q  <= '0;
            ptr_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            case (lock_q)
                ARB_IDLE: begin
                    if (xfer) begin
                        ptr_q <= ptr_d;
                    end else if (bus.s_req_valid) begin
                        lock_q <= ARB_HOLD;
                        gnt_q  <= sel;
                    end
                end
                ARB_HOLD: begin
                    if (xfer) begin
                        lock_q <= ARB_IDLE;
                        ptr_q  <= ptr_d;
                    end
                end
                default: lock_q <= ARB_IDLE;
            endcase
        end
    end

    resp_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (RESP_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (sel),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule
`default_nettype wire
